lsu_mem_ctrl: RTL and testbench

- Load/store unit directly downstream of the core ALU.
- Consumes the ALU result as the effective address of a load/store.
- Runs a req/ack transaction on the data-memory bus: byte enables, store-data replication, load-data extraction with sign/zero extension.
- Stalls the core until the access completes, faults or times out.

---
 rtl/lsu_mem_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: load/store unit sitting after the core ALU.
// Takes the ALU result as the effective address and runs one req/ack
// transaction on the data-memory bus. It generates byte enables and
// replicated store data. Load data is extracted with sign or zero extension.
// The core is stalled until the access completes, faults or times out.
//
// Ports:
//   clk, rst        - rising-edge clock, synchronous active-high reset
//   lsu_req/we/size - core access request, direction and size code
//   lsu_addr        - effective address
//   lsu_data_in     - store data
//   lsu_data_out    - registered load result
//   lsu_stall       - hold PC and all lsu_* inputs while high
//   lsu_fault       - one-cycle pulse: misaligned, illegal size or timeout
//   mem_req/we/be   - registered bus request, write enable, byte enables
//   mem_addr/wdata  - word address and replicated store data
//   mem_rdata/ack   - read data, qualified by the completion strobe
module lsu_mem_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lsu_req,
  input  logic        lsu_we,
  input  logic [2:0]  lsu_size,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_data_in,
  output logic [31:0] lsu_data_out,
  output logic        lsu_stall,
  output logic        lsu_fault,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter value of the last WAIT cycle that may still see an ack.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic             TO_EN    = (TIMEOUT != 0);

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [2:0]        size_q;
  logic [1:0]        off_q;
  logic [31:0]       data_q;
  logic              fault_q;
  logic              req_q;
  logic              we_q;
  logic [3:0]        be_q;
  logic [31:0]       addr_q;
  logic [31:0]       wdata_q;

  logic              legal_d;
  logic [3:0]        be_d;
  logic [31:0]       wdata_d;
  logic [31:0]       ext_d;

  function automatic logic is_legal(input logic we, input logic [2:0] size,
                                    input logic [1:0] off);
    logic ok;
    ok = 1'b0;
    case (size)
      3'd0:    ok = 1'b1;
      3'd1:    ok = ~off[0];
      3'd2:    ok = (off == 2'b00);
      3'd4:    ok = ~we;
      3'd5:    ok = ~we & ~off[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] off);
    logic [3:0] be;
    be = 4'b0000;
    case (size)
      3'd0, 3'd4: be = 4'b0001 << off;
      3'd1, 3'd5: be = off[1] ? 4'b1100 : 4'b0011;
      3'd2:       be = 4'b1111;
      default:    be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] size, input logic [31:0] d);
    logic [31:0] w;
    w = d;
    case (size)
      3'd0:    w = {4{d[7:0]}};
      3'd1:    w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  function automatic logic [31:0] load_data(input logic [2:0] size, input logic [1:0] off,
                                            input logic [31:0] rd);
    logic [31:0] sh;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    sh = rd >> {off, 3'b000};
    b  = sh[7:0];
    h  = off[1] ? rd[31:16] : rd[15:0];
    r  = rd;
    case (size)
      3'd0:    r = {{24{b[7]}}, b};
      3'd1:    r = {{16{h[15]}}, h};
      3'd4:    r = {24'h000000, b};
      3'd5:    r = {16'h0000, h};
      default: r = rd;
    endcase
    return r;
  endfunction

  assign legal_d = is_legal(lsu_we, lsu_size, lsu_addr[1:0]);
  assign be_d    = byte_en(lsu_size, lsu_addr[1:0]);
  assign wdata_d = store_data(lsu_size, lsu_data_in);
  // Extraction uses the offset/size captured at request time, not the live address.
  assign ext_d   = load_data(size_q, off_q, mem_rdata);

  // Access sequencer: IDLE -> (WAIT) -> DONE -> IDLE, all bus outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      size_q  <= 3'd0;
      off_q   <= 2'd0;
      data_q  <= 32'h0000_0000;
      fault_q <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= 4'b0000;
      addr_q  <= 32'h0000_0000;
      wdata_q <= 32'h0000_0000;
    end else begin
      fault_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q <= {CNT_W{1'b0}};
          if (lsu_req) begin
            if (legal_d) begin
              req_q   <= 1'b1;
              we_q    <= lsu_we;
              be_q    <= be_d;
              addr_q  <= {lsu_addr[31:2], 2'b00};
              wdata_q <= wdata_d;
              size_q  <= lsu_size;
              off_q   <= lsu_addr[1:0];
              state_q <= WAIT;
            end else begin
              // Illegal access: fault without touching the bus.
              fault_q <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        WAIT: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (mem_ack) begin
            // Ack wins over a timeout landing in the same cycle.
            req_q   <= 1'b0;
            be_q    <= 4'b0000;
            if (!we_q) begin
              data_q <= ext_d;
            end
            state_q <= DONE;
          end else if (TO_EN && (cnt_q == CNT_LAST)) begin
            req_q   <= 1'b0;
            be_q    <= 4'b0000;
            fault_q <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          cnt_q   <= {CNT_W{1'b0}};
          state_q <= IDLE;
        end
        default: begin
          cnt_q   <= {CNT_W{1'b0}};
          req_q   <= 1'b0;
          be_q    <= 4'b0000;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Stall releases only in DONE so the core sees the result/fault that cycle.
  assign lsu_stall    = lsu_req & (state_q != DONE);
  assign lsu_data_out = data_q;
  assign lsu_fault    = fault_q;
  assign mem_req      = req_q;
  assign mem_we       = we_q;
  assign mem_be       = be_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        lsu_req;
  logic        lsu_we;
  logic [2:0]  lsu_size;
  logic [31:0] lsu_addr;
  logic [31:0] lsu_data_in;
  logic [31:0] lsu_data_out;
  logic        lsu_stall;
  logic        lsu_fault;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  always #5 clk = ~clk;

  lsu_mem_ctrl #(.TIMEOUT(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_size(lsu_size),
    .lsu_addr(lsu_addr), .lsu_data_in(lsu_data_in),
    .lsu_data_out(lsu_data_out), .lsu_stall(lsu_stall), .lsu_fault(lsu_fault),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  typedef struct {
    logic [31:0] data;
    logic        fault;
    int          stalls;
    int          reqs;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] prev_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] data, input logic fault, input int stalls,
                              input int reqs, input logic [3:0] be, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic we);
    exp_t e;
    e.data = data; e.fault = fault; e.stalls = stalls; e.reqs = reqs;
    e.be = be; e.addr = addr; e.wdata = wdata; e.we = we;
    return e;
  endfunction

  // Reference load extraction: shift the word down, then extend.
  function automatic logic [31:0] model_load(input logic [2:0] size, input logic [1:0] off,
                                             input logic [31:0] rd);
    logic [31:0] sh;
    sh = rd >> (8 * int'(off));
    case (size)
      3'd0:    return {{24{sh[7]}}, sh[7:0]};
      3'd4:    return {24'h000000, sh[7:0]};
      3'd1:    return {{16{sh[15]}}, sh[15:0]};
      3'd5:    return {16'h0000, sh[15:0]};
      default: return rd;
    endcase
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] size, input logic [1:0] off);
    int n;
    logic [3:0] m;
    n = (size == 3'd2) ? 4 : ((size == 3'd1 || size == 3'd5) ? 2 : 1);
    m = 4'((1 << n) - 1);
    return 4'(m << off);
  endfunction

  // Drive one access, push its expectation, then follow it to DONE and compare.
  task automatic access(input string name, input logic we, input logic [2:0] size,
                        input logic [31:0] addr, input logic [31:0] din,
                        input logic [31:0] rdata, input int ack_at, input exp_t e);
    exp_t g;
    int stall_n, req_n;
    bit done;
    logic [3:0] be_s;
    logic [31:0] addr_s, wd_s;
    logic we_s;
    sb.push_back(e);
    lsu_req = 1'b1; lsu_we = we; lsu_size = size; lsu_addr = addr;
    lsu_data_in = din; mem_rdata = rdata;
    #1;
    stall_n = 0; req_n = 0; done = 1'b0;
    be_s = 4'h0; addr_s = 32'h0; wd_s = 32'h0; we_s = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      if (lsu_stall) stall_n++;
      if (mem_req) begin
        req_n++;
        if (req_n == 1) begin
          be_s = mem_be; addr_s = mem_addr; wd_s = mem_wdata; we_s = mem_we;
        end
        mem_ack = (req_n == ack_at);
      end else begin
        mem_ack = 1'b0;
      end
      if (!lsu_stall) begin
        done = 1'b1;
        g = sb.pop_front();
        chk({name, "_data"}, lsu_data_out, g.data);
        chk({name, "_fault"}, {31'h0, lsu_fault}, {31'h0, g.fault});
        chk({name, "_stalls"}, stall_n, g.stalls);
        chk({name, "_reqs"}, req_n, g.reqs);
        chk({name, "_be_done"}, {28'h0, mem_be}, 32'h0);
        if (g.reqs > 0) begin
          chk({name, "_be"}, {28'h0, be_s}, {28'h0, g.be});
          chk({name, "_addr"}, addr_s, g.addr);
          chk({name, "_we"}, {31'h0, we_s}, {31'h0, g.we});
          if (g.we) chk({name, "_wdata"}, wd_s, g.wdata);
        end
      end else begin
        @(negedge clk);
        #1;
      end
    end
    if (!done) begin
      chk({name, "_bound"}, 32'h0, 32'h1);
      void'(sb.pop_front());
    end
    lsu_req = 1'b0; mem_ack = 1'b0;
    @(negedge clk);
    #1;
    chk({name, "_fault_clr"}, {31'h0, lsu_fault}, 32'h0);
    chk({name, "_idle_req"}, {31'h0, mem_req}, 32'h0);
  endtask

  initial begin
    rst = 1'b1; lsu_req = 1'b0; lsu_we = 1'b0; lsu_size = 3'd0;
    lsu_addr = 32'h0; lsu_data_in = 32'h0; mem_rdata = 32'h0; mem_ack = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_data", lsu_data_out, 32'h0);
    chk("rst_ctl", {26'h0, lsu_fault, mem_req, mem_we, mem_be}, 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("idle_stall", {31'h0, lsu_stall}, 32'h0);
    prev_data = 32'h0;

    access("lw", 1'b0, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 1,
           mk(32'hDEADBEEF, 1'b0, 2, 1, 4'b1111, 32'h100, 32'h0, 1'b0));
    access("lb", 1'b0, 3'd0, 32'h203, 32'h0, 32'h80112233, 1,
           mk(32'hFFFFFF80, 1'b0, 2, 1, 4'b1000, 32'h200, 32'h0, 1'b0));
    access("lbu", 1'b0, 3'd4, 32'h203, 32'h0, 32'h80112233, 2,
           mk(32'h00000080, 1'b0, 3, 2, 4'b1000, 32'h200, 32'h0, 1'b0));
    access("sh", 1'b1, 3'd1, 32'h42, 32'h1234ABCD, 32'hFFFFFFFF, 1,
           mk(32'h00000080, 1'b0, 2, 1, 4'b1100, 32'h40, 32'hABCDABCD, 1'b1));
    access("sb", 1'b1, 3'd0, 32'h13, 32'h000000A5, 32'hFFFFFFFF, 1,
           mk(32'h00000080, 1'b0, 2, 1, 4'b1000, 32'h10, 32'hA5A5A5A5, 1'b1));
    access("mis_w", 1'b0, 3'd2, 32'h102, 32'h0, 32'hFFFFFFFF, 1,
           mk(32'h00000080, 1'b1, 1, 0, 4'b0, 32'h0, 32'h0, 1'b0));
    access("st_bu", 1'b1, 3'd4, 32'h104, 32'h0, 32'hFFFFFFFF, 1,
           mk(32'h00000080, 1'b1, 1, 0, 4'b0, 32'h0, 32'h0, 1'b0));
    access("size3", 1'b0, 3'd3, 32'h104, 32'h0, 32'hFFFFFFFF, 1,
           mk(32'h00000080, 1'b1, 1, 0, 4'b0, 32'h0, 32'h0, 1'b0));
    access("mis_hu", 1'b0, 3'd5, 32'h105, 32'h0, 32'hFFFFFFFF, 1,
           mk(32'h00000080, 1'b1, 1, 0, 4'b0, 32'h0, 32'h0, 1'b0));
    access("tmo", 1'b0, 3'd2, 32'h300, 32'h0, 32'h12345678, 0,
           mk(32'h00000080, 1'b1, 5, 4, 4'b1111, 32'h300, 32'h0, 1'b0));
    access("ack4", 1'b0, 3'd2, 32'h304, 32'h0, 32'h55AA1234, 4,
           mk(32'h55AA1234, 1'b0, 5, 4, 4'b1111, 32'h304, 32'h0, 1'b0));
    prev_data = 32'h55AA1234;

    for (int i = 0; i < 6; i++) begin
      logic [2:0]  sz;
      logic [1:0]  off;
      logic [31:0] ad, rd, ex;
      int          ak;
      case ($urandom_range(0, 3))
        0: sz = 3'd0;
        1: sz = 3'd1;
        2: sz = 3'd4;
        default: sz = 3'd5;
      endcase
      off = 2'($urandom_range(0, 3));
      if (sz == 3'd1 || sz == 3'd5) off[0] = 1'b0;
      ad = ($urandom & 32'hFFFF_FFFC) | {30'h0, off};
      rd = $urandom;
      ak = $urandom_range(1, 3);
      ex = model_load(sz, off, rd);
      access($sformatf("rnd%0d", i), 1'b0, sz, ad, 32'h0, rd, ak,
             mk(ex, 1'b0, ak + 1, ak, model_be(sz, off), ad & 32'hFFFF_FFFC, 32'h0, 1'b0));
      prev_data = ex;
    end

    // Reset in the middle of WAIT, then a late ack that must be ignored.
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_size = 3'd2; lsu_addr = 32'h400;
    mem_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    #1;
    chk("rw_req", {31'h0, mem_req}, 32'h1);
    rst = 1'b1; lsu_req = 1'b0;
    @(negedge clk);
    #1;
    chk("rw_req0", {31'h0, mem_req}, 32'h0);
    chk("rw_ctl", {26'h0, lsu_fault, mem_req, mem_we, mem_be}, 32'h0);
    chk("rw_addr", mem_addr, 32'h0);
    chk("rw_data", lsu_data_out, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    chk("rw_late_data", lsu_data_out, 32'h0);
    chk("rw_late_req", {31'h0, mem_req}, 32'h0);
    @(negedge clk);
    #1;
    chk("rw_after", {31'h0, lsu_stall | mem_req | lsu_fault}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
